// File: rtl/pcm_frame_packer.sv
// Packs one captured multi-channel PCM frame into a byte stream (optional sync/seq header)
// for a full-aware FIFO write port; frames arriving while busy are dropped and counted.
module pcm_frame_packer #(
  parameter int          SAMPLE_WIDTH = 24,
  parameter int          NUM_CHANNELS = 2,
  parameter int          HEADER_EN    = 1,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] sample_data,
  input  logic                                 sample_valid,
  input  logic                                 big_endian,
  output logic                                 sample_ready,
  input  logic                                 fifo_full,
  output logic                                 fifo_wr_en,
  output logic [7:0]                           fifo_data,
  output logic                                 busy,
  output logic                                 frame_drop,
  output logic [15:0]                          drop_count
);

  localparam int BYTES  = SAMPLE_WIDTH / 8;
  localparam int NBYTES = NUM_CHANNELS * BYTES;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int NSLOT  = 1 << IDX_W;
  localparam int FW     = NUM_CHANNELS * SAMPLE_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, HDR_SYNC, HDR_SEQ, DATA} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       seq_q, seq_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic             be_q, be_d;
  logic [15:0]      drop_count_q, drop_count_d;
  logic             frame_drop_q, frame_drop_d;

  logic             wr_en, last_byte, ready, capture;
  state_t           start_state;
  logic [NSLOT-1:0][7:0] le_bytes, be_bytes;

  // Byte tables in stream order for both endiannesses; the index selects directly.
  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
    for (genvar b = 0; b < BYTES; b++) begin : g_b
      assign le_bytes[ch*BYTES+b] = frame_q[ch*SAMPLE_WIDTH + b*8 +: 8];
      assign be_bytes[ch*BYTES+b] = frame_q[ch*SAMPLE_WIDTH + (BYTES-1-b)*8 +: 8];
    end
  end
  for (genvar p = NBYTES; p < NSLOT; p++) begin : g_pad
    assign le_bytes[p] = 8'h00;
    assign be_bytes[p] = 8'h00;
  end

  assign start_state = (HEADER_EN != 0) ? HDR_SYNC : DATA;
  assign wr_en       = (state_q != IDLE) && !fifo_full;
  assign last_byte   = (state_q == DATA) && (idx_q == LAST_IDX);
  assign ready       = (state_q == IDLE) || (last_byte && !fifo_full);
  assign capture     = sample_valid && ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    seq_d        = seq_q;
    frame_d      = frame_q;
    be_d         = be_q;
    frame_drop_d = sample_valid && !ready;
    drop_count_d = drop_count_q;
    if (frame_drop_d && (drop_count_q != 16'hFFFF))
      drop_count_d = drop_count_q + 16'd1;

    case (state_q)
      HDR_SYNC: if (wr_en) state_d = HDR_SEQ;
      HDR_SEQ: begin
        if (wr_en) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (wr_en) begin
          if (last_byte) begin
            seq_d   = seq_q + 8'd1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: ;
    endcase

    // A capture on the last byte overrides the return to IDLE for gapless frames.
    if (capture) begin
      frame_d = sample_data;
      be_d    = big_endian;
      idx_d   = '0;
      state_d = start_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      seq_q        <= 8'h00;
      frame_q      <= '0;
      be_q         <= 1'b0;
      drop_count_q <= 16'h0000;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      seq_q        <= seq_d;
      frame_q      <= frame_d;
      be_q         <= be_d;
      drop_count_q <= drop_count_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  always_comb begin
    fifo_data = 8'h00;
    case (state_q)
      HDR_SYNC: fifo_data = SYNC_BYTE;
      HDR_SEQ:  fifo_data = seq_q;
      DATA:     fifo_data = be_q ? be_bytes[idx_q] : le_bytes[idx_q];
      default:  fifo_data = 8'h00;
    endcase
  end

  assign fifo_wr_en   = wr_en;
  assign sample_ready = ready;
  assign busy         = (state_q != IDLE);
  assign frame_drop   = frame_drop_q;
  assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Scoreboard bench: default packer (u0) and a 16-bit/1-ch/no-header packer (u1)
// against a byte-list reference model; a negedge monitor pops and compares.
module tb_pcm_frame_packer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v0, v1, f0, f1, b0, b1;
  logic [47:0] d0;
  logic [15:0] d1;
  logic        r0, r1, w0, w1, bz0, bz1, fd0, fd1;
  logic [7:0]  q0, q1;
  logic [15:0] c0, c1;

  pcm_frame_packer u0 (
    .clk(clk), .rst_n(rst_n), .sample_data(d0), .sample_valid(v0), .big_endian(b0),
    .sample_ready(r0), .fifo_full(f0), .fifo_wr_en(w0), .fifo_data(q0), .busy(bz0),
    .frame_drop(fd0), .drop_count(c0));

  pcm_frame_packer #(.SAMPLE_WIDTH(16), .NUM_CHANNELS(1), .HEADER_EN(0)) u1 (
    .clk(clk), .rst_n(rst_n), .sample_data(d1), .sample_valid(v1), .big_endian(b1),
    .sample_ready(r1), .fifo_full(f1), .fifo_wr_en(w1), .fifo_data(q1), .busy(bz1),
    .frame_drop(fd1), .drop_count(c1));

  int vectors = 0;
  int errors  = 0;

  // Reference model: expected byte queue per DUT plus bytes still owed for the current frames.
  logic [7:0]  eq [2][256];
  logic [7:0]  hd [2];
  logic [7:0]  tl [2];
  int          outs [2];
  logic [7:0]  seqm [2];
  logic [15:0] drops [2];
  logic        dp [2];
  int          busyc [2];
  logic [7:0]  log0 [$];
  logic [7:0]  log1 [$];

  function automatic int cfg_sw(int k);  return (k == 0) ? 24 : 16; endfunction
  function automatic int cfg_nch(int k); return (k == 0) ? 2 : 1;   endfunction
  function automatic bit cfg_hdr(int k); return (k == 0);           endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset(int k);
    hd[k] = 8'd0; tl[k] = 8'd0; outs[k] = 0; seqm[k] = 8'd0; drops[k] = 16'd0; dp[k] = 1'b0;
  endtask

  task automatic push(int k, logic [7:0] v);
    eq[k][tl[k]] = v;
    tl[k] = tl[k] + 8'd1;
  endtask

  task automatic model_step();
    logic vk, fk, bk, rdy;
    logic [63:0] s;
    int by;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        model_reset(k);
      end else begin
        vk = (k == 0) ? v0 : v1;
        fk = (k == 0) ? f0 : f1;
        bk = (k == 0) ? b0 : b1;
        s  = (k == 0) ? {16'h0, d0} : {48'h0, d1};
        by = cfg_sw(k) / 8;
        rdy = (outs[k] == 0) || (outs[k] == 1 && !fk);
        if (outs[k] > 0 && !fk) outs[k]--;
        dp[k] = vk && !rdy;
        if (dp[k] && drops[k] != 16'hFFFF) drops[k]++;
        if (vk && rdy) begin
          if (cfg_hdr(k)) begin
            push(k, 8'hA5);
            push(k, seqm[k]);
          end
          for (int ch = 0; ch < cfg_nch(k); ch++)
            for (int b = 0; b < by; b++) begin
              int bi;
              bi = bk ? (by - 1 - b) : b;
              push(k, s[ch*cfg_sw(k) + bi*8 +: 8]);
            end
          outs[k] += (cfg_hdr(k) ? 2 : 0) + cfg_nch(k) * by;
          seqm[k] = seqm[k] + 8'd1;
        end
      end
    end
  endtask

  task automatic mon(int k);
    logic rdy, wr, bz, fd, fk, eb, ew, er;
    logic [7:0] dat;
    logic [15:0] cnt;
    rdy = (k == 0) ? r0 : r1;   wr  = (k == 0) ? w0 : w1;
    bz  = (k == 0) ? bz0 : bz1; fd  = (k == 0) ? fd0 : fd1;
    dat = (k == 0) ? q0 : q1;   cnt = (k == 0) ? c0 : c1;
    fk  = (k == 0) ? f0 : f1;
    if (!rst_n) begin
      chk("rst_ready", 32'(rdy), 1); chk("rst_wr_en", 32'(wr), 0);
      chk("rst_busy", 32'(bz), 0);   chk("rst_data", 32'(dat), 0);
      chk("rst_drop_count", 32'(cnt), 0); chk("rst_frame_drop", 32'(fd), 0);
    end else begin
      eb = outs[k] > 0;
      ew = eb && !fk;
      er = (outs[k] == 0) || (outs[k] == 1 && !fk);
      chk("wr_en", 32'(wr), 32'(ew));
      chk("busy", 32'(bz), 32'(eb));
      chk("sample_ready", 32'(rdy), 32'(er));
      chk("frame_drop", 32'(fd), 32'(dp[k]));
      chk("drop_count", 32'(cnt), 32'(drops[k]));
      if (eb) begin
        if (hd[k] == tl[k]) chk("queue_underflow", 1, 0);
        else begin
          chk("fifo_data", 32'(dat), 32'(eq[k][hd[k]]));
          if (ew) begin
            if (k == 0) log0.push_back(dat); else log1.push_back(dat);
            hd[k] = hd[k] + 8'd1;
          end
        end
      end else begin
        chk("idle_data", 32'(dat), 0);
      end
      if (bz) busyc[k]++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) mon(k);
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_log(int k, string nm, int n, logic [7:0] ex [16]);
    int sz;
    sz = (k == 0) ? log0.size() : log1.size();
    chk({nm, "_len"}, 32'(sz), 32'(n));
    for (int i = 0; i < n && i < sz; i++)
      chk(nm, 32'((k == 0) ? log0[i] : log1[i]), 32'(ex[i]));
  endtask

  task automatic wait_last(int k);
    int n;
    n = 0;
    while (outs[k] != 1 && n < 50) begin cyc(); n++; end
    if (n >= 50) chk("wait_last_timeout", 1, 0);
  endtask

  task automatic clear_logs();
    log0.delete(); log1.delete(); busyc[0] = 0; busyc[1] = 0;
  endtask

  localparam logic [47:0] PAT = {24'hABCDEF, 24'h123456};

  initial begin
    logic [7:0] ex [16];
    v0 = 0; v1 = 0; f0 = 0; f1 = 0; b0 = 0; b1 = 0; d0 = '0; d1 = '0;
    model_reset(0); model_reset(1);
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;

    // Little endian default frame
    clear_logs();
    d0 = PAT; b0 = 0; v0 = 1; cyc(); v0 = 0;
    repeat (10) cyc();
    ex = '{8'hA5, 8'h00, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_log(0, "le_frame", 8, ex);
    chk("le_busy_cycles", 32'(busyc[0]), 8);

    // Big endian second frame
    clear_logs();
    b0 = 1; v0 = 1; cyc(); v0 = 0; b0 = 0;
    repeat (10) cyc();
    ex = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_log(0, "be_frame", 8, ex);

    // Backpressure while byte 4 is presented
    clear_logs();
    v0 = 1; cyc(); v0 = 0;
    repeat (4) cyc();
    f0 = 1; repeat (3) cyc(); f0 = 0;
    repeat (10) cyc();
    ex = '{8'hA5, 8'h02, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_log(0, "bp_frame", 8, ex);
    chk("bp_busy_cycles", 32'(busyc[0]), 11);

    // Drop mid-frame, then back-to-back capture on the last byte
    clear_logs();
    v0 = 1; cyc(); v0 = 0;
    repeat (3) cyc();
    v0 = 1; cyc(); v0 = 0;
    chk("drop_pulse", 32'(fd0), 1);
    chk("drop_count_one", 32'(c0), 1);
    wait_last(0);
    b0 = 1; v0 = 1; cyc(); v0 = 0; b0 = 0;
    repeat (10) cyc();
    ex = '{8'hA5, 8'h03, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB,
           8'hA5, 8'h04, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    chk_log(0, "b2b_frames", 16, ex);
    chk("b2b_busy_cycles", 32'(busyc[0]), 16);

    // Reset during byte 5
    v0 = 1; cyc(); v0 = 0;
    repeat (5) cyc();
    rst_n = 1'b0; model_reset(0); model_reset(1);
    #2;
    chk("reset_wr_en", 32'(w0), 0);
    chk("reset_busy", 32'(bz0), 0);
    chk("reset_drop_count", 32'(c0), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    clear_logs();
    v0 = 1; cyc(); v0 = 0;
    repeat (10) cyc();
    ex = '{8'hA5, 8'h00, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_log(0, "post_reset_frame", 8, ex);

    // Narrow, headerless instance
    clear_logs();
    d1 = 16'hBEEF; b1 = 0; v1 = 1; cyc(); v1 = 0;
    repeat (4) cyc();
    ex = '{8'hEF, 8'hBE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_log(1, "narrow_le", 2, ex);
    chk("narrow_busy_cycles", 32'(busyc[1]), 2);
    clear_logs();
    b1 = 1; v1 = 1; cyc(); v1 = 0; b1 = 0;
    repeat (4) cyc();
    ex = '{8'hBE, 8'hEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_log(1, "narrow_be", 2, ex);

    // Randomised traffic with backpressure on both instances
    for (int i = 0; i < 3000; i++) begin
      v0 = ($urandom_range(0, 3) == 0);
      f0 = ($urandom_range(0, 4) == 0);
      b0 = $urandom_range(0, 1);
      d0 = {$urandom, $urandom};
      v1 = ($urandom_range(0, 2) == 0);
      f1 = ($urandom_range(0, 3) == 0);
      b1 = $urandom_range(0, 1);
      d1 = $urandom;
      cyc();
    end
    v0 = 0; v1 = 0; f0 = 0; f1 = 0;
    repeat (20) cyc();
    chk("drain_u0", 32'(tl[0] - hd[0]), 0);
    chk("drain_u1", 32'(tl[1] - hd[1]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
